// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, mid-bit LSB-first data sampling, optional parity, stop check.
// Optional two-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
module uart_rx #(
    parameter int unsigned BAUD              = 9600,
    parameter int unsigned clk_freq          = 50_000_000,
    parameter int unsigned oversampling_rate = 16,
    parameter int unsigned data_wd           = 8,
    parameter int unsigned parity            = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               tick,
    output logic [data_wd-1:0] dout,
    output logic               rx_done,
    output logic               rx_busy,
    output logic               parity_err,
    output logic               frame_err
);

    localparam int unsigned TC_W   = $clog2(oversampling_rate);
    localparam int unsigned BI_W   = $clog2(data_wd + 1);
    localparam bit          PAR_EN = (parity == 1) || (parity == 2);

    // Baud and clock rates only document the intended setup; an empty block marks a bad pairing.
    if (clk_freq < BAUD * oversampling_rate) begin : g_rate_out_of_range
    end

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        START  = 6'b000010,
        DATA   = 6'b000100,
        PARITY = 6'b001000,
        STOP   = 6'b010000,
        DONE   = 6'b100000
    } state_t;

    state_t              state, state_n;
    logic [TC_W-1:0]     tick_cnt, tick_cnt_n;
    logic [BI_W-1:0]     bit_idx, bit_idx_n;
    logic [data_wd-1:0]  shreg, shreg_n;
    logic                perr, perr_n;
    logic                armed, armed_n;
    logic [data_wd-1:0]  dout_n;
    logic                rx_done_n, rx_busy_n, parity_err_n, frame_err_n;
    logic                rx_s;
    logic                last_tick;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    assign last_tick = tick && (tick_cnt == TC_W'(oversampling_rate - 1));

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        perr_n       = perr;
        armed_n      = armed | rx_s;
        dout_n       = dout;
        rx_done_n    = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;

        case (state)
            IDLE: begin
                if (!rx_s && armed) begin
                    state_n   = START;
                    bit_idx_n = '0;
                end
            end
            START: begin
                if (tick && (tick_cnt == TC_W'(oversampling_rate / 2 - 1)))
                    state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (last_tick) begin
                    for (int i = 0; i < int'(data_wd); i++)
                        if (bit_idx == BI_W'(i)) shreg_n[i] = rx_s;
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == BI_W'(data_wd - 1))
                        state_n = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_tick) begin
                    perr_n  = (parity == 1) ? ~(^{shreg, rx_s}) : (^{shreg, rx_s});
                    state_n = STOP;
                end
            end
            STOP: begin
                // Outputs load here so they change together with rx_done.
                if (last_tick) begin
                    state_n      = DONE;
                    rx_done_n    = 1'b1;
                    dout_n       = shreg;
                    parity_err_n = perr;
                    frame_err_n  = ~rx_s;
                    if (!rx_s) armed_n = 1'b0;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n != state)
            tick_cnt_n = '0;
        else if (tick && (state != IDLE) && (state != DONE))
            tick_cnt_n = tick_cnt + 1'b1;

        rx_busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            armed      <= 1'b1;
            dout       <= '0;
            rx_done    <= 1'b0;
            rx_busy    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            perr       <= perr_n;
            armed      <= armed_n;
            dout       <= dout_n;
            rx_done    <= rx_done_n;
            rx_busy    <= rx_busy_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an odd-parity and an even-parity receiver share one serial line.
module tb_uart_rx;

    localparam int unsigned OSR = 16;
    localparam int unsigned DW  = 8;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic tick;

    logic [DW-1:0] dout0, dout1;
    logic          done0, done1, busy0, busy1, perr0, perr1, ferr0, ferr1;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } exp_t;

    exp_t          q[2][$];
    logic [DW-1:0] exp_last[2];
    logic          exp_pe[2];
    logic          exp_fe[2];
    int            checks = 0;
    int            passes = 0;
    int            tick_div = 1;
    int            tick_ctr = 0;

    uart_rx #(.oversampling_rate(OSR), .data_wd(DW), .parity(1)) u_odd (
        .clk(clk), .rst(rst), .rx(rx), .tick(tick),
        .dout(dout0), .rx_done(done0), .rx_busy(busy0),
        .parity_err(perr0), .frame_err(ferr0)
    );

    uart_rx #(.oversampling_rate(OSR), .data_wd(DW), .parity(2)) u_even (
        .clk(clk), .rst(rst), .rx(rx), .tick(tick),
        .dout(dout1), .rx_done(done1), .rx_busy(busy1),
        .parity_err(perr1), .frame_err(ferr1)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one pulse every tick_div clocks.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_ctr >= tick_div - 1) begin
                tick     = 1'b1;
                tick_ctr = 0;
            end else begin
                tick     = 1'b0;
                tick_ctr = tick_ctr + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic mon(input int k, input logic [DW-1:0] d, input logic pe, input logic fe);
        exp_t e;
        if (q[k].size() == 0) begin
            checks++;
            $display("FAIL dut%0d spurious rx_done: got dout %0h with no frame pending", k, d);
        end else begin
            e = q[k].pop_front();
            check($sformatf("dut%0d dout", k), int'(d), int'(e.d));
            check($sformatf("dut%0d parity_err", k), int'(pe), int'(e.pe));
            check($sformatf("dut%0d frame_err", k), int'(fe), int'(e.fe));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done0) mon(0, dout0, perr0, ferr0);
        if (!rst && done1) mon(1, dout1, perr1, ferr1);
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(OSR);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(n);
    endtask

    // Reference: odd mode wants an odd count of ones over data+parity, even mode an even count.
    task automatic send_frame(input logic [DW-1:0] data, input logic pbit, input logic stop);
        int   ones;
        exp_t e;
        ones = $countones(data) + int'(pbit);
        for (int k = 0; k < 2; k++) begin
            e.d  = data;
            e.pe = (k == 0) ? (ones % 2 == 0) : (ones % 2 == 1);
            e.fe = !stop;
            q[k].push_back(e);
            exp_last[k] = data;
            exp_pe[k]   = e.pe;
            exp_fe[k]   = e.fe;
        end
        drive_bit(1'b0);
        for (int i = 0; i < int'(DW); i++) drive_bit(data[i]);
        drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic check_outputs_zero();
        check("rst dout0", int'(dout0), 0);
        check("rst dout1", int'(dout1), 0);
        check("rst rx_done", int'({done0, done1}), 0);
        check("rst rx_busy", int'({busy0, busy1}), 0);
        check("rst parity_err", int'({perr0, perr1}), 0);
        check("rst frame_err", int'({ferr0, ferr1}), 0);
    endtask

    initial begin
        logic [DW-1:0] data;
        logic          pbit;
        logic          stop;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst = 1'b0;
        idle(OSR);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(OSR);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(OSR);

        // Break: line low through the stop bit and beyond; only one frame may come out.
        send_frame(8'h00, 1'b0, 1'b0);
        wait_ticks(3 * OSR);
        idle(2 * OSR);

        // Four-tick low glitch while idle is a false start.
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        check("glitch busy0", int'(busy0), 1);
        check("glitch busy1", int'(busy1), 1);
        wait_ticks(1);
        idle(OSR);
        @(negedge clk);
        check("glitch busy dropped", int'({busy0, busy1}), 0);
        check("glitch dout0 held", int'(dout0), int'(exp_last[0]));
        check("glitch dout1 held", int'(dout1), int'(exp_last[1]));
        check("glitch flags0 held", int'({perr0, ferr0}), int'({exp_pe[0], exp_fe[0]}));
        check("glitch flags1 held", int'({perr1, ferr1}), int'({exp_pe[1], exp_fe[1]}));

        // Reset after the third data bit of a 0xFF frame.
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check_outputs_zero();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) exp_last[k] = '0;
        idle(OSR);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(OSR);

        // Back-to-back frames with a tick every third clock.
        tick_div = 3;
        send_frame(8'h12, ~^8'h12, 1'b1);
        send_frame(8'h34, ~^8'h34, 1'b1);
        idle(OSR);

        for (int n = 0; n < 24; n++) begin
            tick_div = int'($urandom_range(1, 3));
            data     = DW'($urandom);
            pbit     = ~^data;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stop     = ($urandom_range(0, 4) != 0);
            send_frame(data, pbit, stop);
            idle(int'($urandom_range(1, 12)));
        end

        idle(2 * OSR);
        check("dut0 frames outstanding", q[0].size(), 0);
        check("dut1 frames outstanding", q[1].size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
